mcast_ctrl: RTL and testbench
=============================

MCAST_CTRL -- requirements
Module: mcast_ctrl

Interface
- REQ-001: Parameter NUM_X, default 14, PE columns per row.
- REQ-002: Parameter NUM_Y, default 3, PE rows.
- REQ-003: Parameter NUM_CH, default 2, independent multicast channels (channel 0 = activations, channel 1 = weights).
- REQ-004: Parameter DATA_W, default 8, payload width.
- REQ-005: Parameter ID_W, default 8, ID and tag width.
- REQ-006: Parameter DROP_ON_MISS, default 1, selects the miss policy: 1 = accept and drop, 0 = stall.
- REQ-007: clk  in  1  single clock; all logic is rising-edge.
- REQ-008: nrst  in  1  reset, synchronous and active-low.
- REQ-009: scan_en_i  in  [NUM_CH]  shift enable for the ID scan chain of each channel.
- REQ-010: scan_data_i  in  [NUM_CH][ID_W]  scan-chain tail input.
- REQ-011: scan_commit_i  in  [NUM_CH]  copies the chain contents into the ID registers.
- REQ-012: in_valid_i / in_ready_o  in / out  [NUM_CH]  input handshake.
- REQ-013: in_data_i  in  [NUM_CH][DATA_W]  payload.
- REQ-014: in_tag_x_i, in_tag_y_i  in  [NUM_CH][ID_W]  target tags.
- REQ-015: pe_ready_i  in  [NUM_CH][NUM_X*NUM_Y]  PE spad ready, indexed x*NUM_Y+y.
- REQ-016: pe_data_o  out  [NUM_CH][DATA_W]  registered payload to the PEs.
- REQ-017: pe_load_o  out  [NUM_CH][NUM_X*NUM_Y]  one-cycle load strobes.
- REQ-018: miss_o  out  [NUM_CH]  no-target indication.
- REQ-019: drop_cnt_o  out  [NUM_CH][16]  count of dropped words.
- REQ-020: cfg_o  out  [NUM_CH]  channel is in the S_CFG state.

Function
- REQ-021: Each channel has a chain of L = NUM_X*NUM_Y+NUM_Y entries; it shifts only when scan_en_i=1: entry[i-1]<=entry[i], entry[L-1]<=scan_data_i.
- REQ-022: On scan_commit_i=1: x_id[x][y]<=entry[x*NUM_Y+y] and y_id[y]<=entry[NUM_X*NUM_Y+y], using the chain values registered before that cycle's shift.
- REQ-023: PE (x,y) matches when both conditions hold: (in_tag_y_i==y_id[y] or in_tag_y_i==all-ones) and (in_tag_x_i==x_id[x][y] or in_tag_x_i==all-ones).
- REQ-024: Each channel has an FSM with states S_CFG and S_RUN; S_CFG is entered on reset.
- REQ-025: S_CFG -> S_RUN on scan_commit_i with scan_en_i=0.
- REQ-026: S_RUN -> S_CFG on scan_en_i=1; a commit in the same cycle still updates the IDs, and the channel stays in S_CFG.
- REQ-027: In S_CFG, in_ready_o=0.
- REQ-028: In S_RUN with at least one match, in_ready_o = AND of pe_ready_i over all matched PEs; this path is combinational.
- REQ-029: On acceptance (valid & ready): pe_data_o<=in_data_i and pe_load_o<=match mask on the next edge; pe_load_o is high for exactly one cycle per accepted word.
- REQ-030: With no match and DROP_ON_MISS=1: in_ready_o=1, the word is dropped, pe_load_o stays 0, miss_o pulses for 1 cycle, and drop_cnt_o increments, saturating at 16'hFFFF.
- REQ-031: With no match and DROP_ON_MISS=0: in_ready_o=0, and miss_o is a level that is high while in_valid_i=1.
- REQ-032: Back-to-back accepted words produce consecutive pe_load_o pulses with no bubble; throughput is 1 word per cycle per channel.
- REQ-033: Channels are fully independent; simultaneous traffic on all channels is legal.
- REQ-034: A load registered in the cycle before entry to S_CFG still issues.
- REQ-035: pe_data_o holds its value when no word is accepted.

Reset
- REQ-036: With nrst=0 at a rising edge: all chain entries, x_id, y_id, pe_data_o, drop_cnt_o and miss_o go to 0.
- REQ-037: With nrst=0 at a rising edge: pe_load_o goes to 0 and every channel goes to S_CFG.
- REQ-038: Reset asserted mid-transfer discards the pending load; no strobe issues after reset.
- REQ-039: in_ready_o=0 during reset and in the first cycle after reset.

Structure
- REQ-040: The shared package mcast_pkg holds the mcast_state_t enum (S_CFG, S_RUN) and the TAG_BCAST constant (all-ones).
- REQ-041: One sub-module, mcast_channel (chain, ID registers, matcher, FSM, output register), is instantiated NUM_CH times by a generate loop.

Verification
- REQ-042: NUM_X=2, NUM_Y=2 (L=6): scan in 6 IDs {0,1,2,3,7,9} and commit -> x_id[0][0]=0, x_id[0][1]=1, x_id[1][0]=2, x_id[1][1]=3, y_id[0]=7, y_id[1]=9, and cfg_o falls.
- REQ-043: Tag (x=2, y=7) with data 8'h5A -> the next cycle has pe_load_o=4'b0100 and pe_data_o=8'h5A, for 1 cycle.
- REQ-044: Tag x=FF, y=9 with pe_ready_i[3]=0 -> in_ready_o=0; raising pe_ready_i[3] gives acceptance, then pe_load_o=4'b1010.
- REQ-045: Tag (x=5, y=7) with DROP_ON_MISS=1 -> in_ready_o=1, one miss_o pulse, drop_cnt_o=1, and pe_load_o=0.
- REQ-046: scan_en_i asserted during a 4-word burst -> the word accepted before S_CFG still loads, and in_ready_o=0 thereafter.
- REQ-047: nrst=0 one cycle after acceptance -> no pe_load_o pulse, all outputs 0, and cfg_o=1.

Source files
------------

// File: rtl/mcast_pkg.sv
// Shared types and constants for the multicast controller: channel FSM
// states, the broadcast tag value and the saturating drop-counter helper.
package mcast_pkg;

  typedef enum logic [0:0] {
    S_CFG = 1'b0,
    S_RUN = 1'b1
  } mcast_state_t;

  localparam int unsigned TAG_MAX_W = 32;
  localparam logic [TAG_MAX_W-1:0] TAG_BCAST = '1;

  localparam int unsigned CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/mcast_channel.sv
// One multicast channel: ID scan chain, ID registers, tag matcher,
// CFG/RUN FSM and the registered payload/load-strobe outputs.
module mcast_channel
  import mcast_pkg::*;
#(
  parameter int NUM_X        = 14,
  parameter int NUM_Y        = 3,
  parameter int DATA_W       = 8,
  parameter int ID_W         = 8,
  parameter bit DROP_ON_MISS = 1'b1
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   scan_en_i,
  input  logic [ID_W-1:0]        scan_data_i,
  input  logic                   scan_commit_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DATA_W-1:0]      in_data_i,
  input  logic [ID_W-1:0]        in_tag_x_i,
  input  logic [ID_W-1:0]        in_tag_y_i,
  input  logic [NUM_X*NUM_Y-1:0] pe_ready_i,
  output logic [DATA_W-1:0]      pe_data_o,
  output logic [NUM_X*NUM_Y-1:0] pe_load_o,
  output logic                   miss_o,
  output logic [CNT_W-1:0]       drop_cnt_o,
  output logic                   cfg_o
);

  localparam int NUM_PE  = NUM_X * NUM_Y;
  localparam int CHAIN_L = NUM_PE + NUM_Y;
  localparam logic [ID_W-1:0] BCAST = TAG_BCAST[ID_W-1:0];

  logic [ID_W-1:0]   chain_q [CHAIN_L];
  logic [ID_W-1:0]   x_id_q  [NUM_PE];
  logic [ID_W-1:0]   y_id_q  [NUM_Y];
  mcast_state_t      state_q;
  mcast_state_t      state_d;
  logic [NUM_PE-1:0] match;
  logic              any_match;
  logic              all_ready;
  logic              run;
  logic              accept;
  logic              load_acc;
  logic              drop_acc;
  logic              miss_q;

  // Scan chain shifts toward entry 0; the newest word enters at the tail.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < CHAIN_L; i++) chain_q[i] <= '0;
    end else if (scan_en_i) begin
      for (int i = 0; i < CHAIN_L - 1; i++) chain_q[i] <= chain_q[i+1];
      chain_q[CHAIN_L-1] <= scan_data_i;
    end
  end

  // Commit samples the pre-shift chain, so a commit coinciding with a
  // shift captures the values that were visible during that cycle.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < NUM_PE; i++) x_id_q[i] <= '0;
      for (int i = 0; i < NUM_Y; i++)  y_id_q[i] <= '0;
    end else if (scan_commit_i) begin
      for (int i = 0; i < NUM_PE; i++) x_id_q[i] <= chain_q[i];
      for (int i = 0; i < NUM_Y; i++)  y_id_q[i] <= chain_q[NUM_PE+i];
    end
  end

  always_comb begin
    match = '0;
    for (int x = 0; x < NUM_X; x++) begin
      for (int y = 0; y < NUM_Y; y++) begin
        match[x*NUM_Y+y] = ((in_tag_y_i == y_id_q[y]) || (in_tag_y_i == BCAST)) &&
                           ((in_tag_x_i == x_id_q[x*NUM_Y+y]) || (in_tag_x_i == BCAST));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CFG:   if (scan_commit_i && !scan_en_i) state_d = S_RUN;
      S_RUN:   if (scan_en_i) state_d = S_CFG;
      default: state_d = S_CFG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) state_q <= S_CFG;
    else       state_q <= state_d;
  end

  assign run       = (state_q == S_RUN);
  assign cfg_o     = (state_q == S_CFG);
  assign any_match = |match;
  assign all_ready = &(pe_ready_i | ~match);

  // Handshake: a word transfers on a rising edge where in_valid_i and
  // in_ready_o are both high; ready may depend combinationally on tags and
  // PE readiness, valid must not depend on ready.
  always_comb begin
    in_ready_o = 1'b0;
    if (nrst && run) in_ready_o = any_match ? all_ready : DROP_ON_MISS;
  end

  assign accept   = in_valid_i && in_ready_o;
  assign load_acc = accept && any_match;
  assign drop_acc = accept && !any_match;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      pe_data_o  <= '0;
      pe_load_o  <= '0;
      miss_q     <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      pe_load_o <= load_acc ? match : '0;
      miss_q    <= drop_acc;
      if (load_acc) pe_data_o <= in_data_i;
      if (drop_acc) drop_cnt_o <= sat_inc(drop_cnt_o);
    end
  end

  // Stall mode never accepts a miss, so the miss flag is a live level.
  assign miss_o = DROP_ON_MISS ? miss_q : (nrst && run && in_valid_i && !any_match);

endmodule

// File: rtl/mcast_ctrl.sv
// Multicast controller top: NUM_CH independent channels delivering tagged
// words to a NUM_X x NUM_Y PE array.
module mcast_ctrl
  import mcast_pkg::*;
#(
  parameter int NUM_X        = 14,
  parameter int NUM_Y        = 3,
  parameter int NUM_CH       = 2,
  parameter int DATA_W       = 8,
  parameter int ID_W         = 8,
  parameter int DROP_ON_MISS = 1
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  logic [NUM_CH-1:0]                   scan_en_i,
  input  logic [NUM_CH-1:0][ID_W-1:0]         scan_data_i,
  input  logic [NUM_CH-1:0]                   scan_commit_i,
  input  logic [NUM_CH-1:0]                   in_valid_i,
  output logic [NUM_CH-1:0]                   in_ready_o,
  input  logic [NUM_CH-1:0][DATA_W-1:0]       in_data_i,
  input  logic [NUM_CH-1:0][ID_W-1:0]         in_tag_x_i,
  input  logic [NUM_CH-1:0][ID_W-1:0]         in_tag_y_i,
  input  logic [NUM_CH-1:0][NUM_X*NUM_Y-1:0]  pe_ready_i,
  output logic [NUM_CH-1:0][DATA_W-1:0]       pe_data_o,
  output logic [NUM_CH-1:0][NUM_X*NUM_Y-1:0]  pe_load_o,
  output logic [NUM_CH-1:0]                   miss_o,
  output logic [NUM_CH-1:0][CNT_W-1:0]        drop_cnt_o,
  output logic [NUM_CH-1:0]                   cfg_o
);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    mcast_channel #(
      .NUM_X        (NUM_X),
      .NUM_Y        (NUM_Y),
      .DATA_W       (DATA_W),
      .ID_W         (ID_W),
      .DROP_ON_MISS (DROP_ON_MISS != 0)
    ) u_chan (
      .clk           (clk),
      .nrst          (nrst),
      .scan_en_i     (scan_en_i[ch]),
      .scan_data_i   (scan_data_i[ch]),
      .scan_commit_i (scan_commit_i[ch]),
      .in_valid_i    (in_valid_i[ch]),
      .in_ready_o    (in_ready_o[ch]),
      .in_data_i     (in_data_i[ch]),
      .in_tag_x_i    (in_tag_x_i[ch]),
      .in_tag_y_i    (in_tag_y_i[ch]),
      .pe_ready_i    (pe_ready_i[ch]),
      .pe_data_o     (pe_data_o[ch]),
      .pe_load_o     (pe_load_o[ch]),
      .miss_o        (miss_o[ch]),
      .drop_cnt_o    (drop_cnt_o[ch]),
      .cfg_o         (cfg_o[ch])
    );
  end

endmodule

// File: tb/tb_mcast_ctrl.sv
// Bench for mcast_ctrl: a 2x2, two-channel drop-mode instance plus a
// one-channel stall-mode instance sharing channel 0 stimulus.
module tb_mcast_ctrl;
  localparam int NX = 2, NY = 2, NCH = 2, DW = 8, IW = 8;
  localparam int NPE = NX * NY;
  localparam int L = NPE + NY;
  localparam int W = 1 + NPE + DW;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  logic [NCH-1:0]          scan_en, scan_commit, in_valid, in_ready, miss, cfg;
  logic [NCH-1:0][IW-1:0]  scan_data, tag_x, tag_y;
  logic [NCH-1:0][DW-1:0]  in_data, pe_data;
  logic [NCH-1:0][NPE-1:0] pe_ready, pe_load;
  logic [NCH-1:0][15:0]    drop_cnt;

  logic [0:0]          s_in_ready, s_miss, s_cfg;
  logic [0:0][DW-1:0]  s_pe_data;
  logic [0:0][NPE-1:0] s_pe_load;
  logic [0:0][15:0]    s_drop_cnt;

  mcast_ctrl #(.NUM_X(NX), .NUM_Y(NY), .NUM_CH(NCH), .DATA_W(DW), .ID_W(IW),
               .DROP_ON_MISS(1)) u_dut (
    .clk(clk), .nrst(nrst), .scan_en_i(scan_en), .scan_data_i(scan_data),
    .scan_commit_i(scan_commit), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_tag_x_i(tag_x), .in_tag_y_i(tag_y),
    .pe_ready_i(pe_ready), .pe_data_o(pe_data), .pe_load_o(pe_load),
    .miss_o(miss), .drop_cnt_o(drop_cnt), .cfg_o(cfg)
  );

  mcast_ctrl #(.NUM_X(NX), .NUM_Y(NY), .NUM_CH(1), .DATA_W(DW), .ID_W(IW),
               .DROP_ON_MISS(0)) u_dut_stall (
    .clk(clk), .nrst(nrst), .scan_en_i(scan_en[0]), .scan_data_i(scan_data[0]),
    .scan_commit_i(scan_commit[0]), .in_valid_i(in_valid[0]), .in_ready_o(s_in_ready),
    .in_data_i(in_data[0]), .in_tag_x_i(tag_x[0]), .in_tag_y_i(tag_y[0]),
    .pe_ready_i(pe_ready[0]), .pe_data_o(s_pe_data), .pe_load_o(s_pe_load),
    .miss_o(s_miss), .drop_cnt_o(s_drop_cnt), .cfg_o(s_cfg)
  );

  int n_tests, n_fail;
  logic [W-1:0] exp_q[$];

  logic [7:0]  ids0 [L] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd9};
  logic [7:0]  ids1 [L] = '{8'd4, 8'd5, 8'd6, 8'd8, 8'd1, 8'd2};
  logic [7:0]  m_chain [NCH][L];
  logic [7:0]  m_xid [NCH][NPE];
  logic [7:0]  m_yid [NCH][NY];
  logic        m_run [NCH];
  logic        m_miss [NCH];
  logic        m_pend [NCH];
  logic [15:0] m_drop [NCH];
  logic [7:0]  m_data [NCH];
  logic        m_known;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset(input int c);
    for (int i = 0; i < L; i++) m_chain[c][i] = '0;
    for (int i = 0; i < NPE; i++) m_xid[c][i] = '0;
    for (int i = 0; i < NY; i++) m_yid[c][i] = '0;
    m_run[c] = 1'b0; m_miss[c] = 1'b0; m_pend[c] = 1'b0;
    m_drop[c] = '0;  m_data[c] = '0;
  endtask

  function automatic logic [NPE-1:0] mdl_match(input int c, input logic [7:0] tx, input logic [7:0] ty);
    logic [NPE-1:0] m;
    m = '0;
    for (int x = 0; x < NX; x++)
      for (int y = 0; y < NY; y++)
        m[x*NY+y] = ((ty == m_yid[c][y]) || (ty == 8'hFF)) &&
                    ((tx == m_xid[c][x*NY+y]) || (tx == 8'hFF));
    return m;
  endfunction

  // One clock: check outputs of the previous edge, predict the next edge.
  task automatic step();
    logic [NPE-1:0] mm, load0;
    logic [W-1:0]   e;
    logic           rdy, acc;
    @(negedge clk);
    load0 = '0;
    for (int c = 0; c < NCH; c++) begin
      if (m_known) begin
        check($sformatf("cfg%0d", c), cfg[c], !m_run[c]);
        if (m_pend[c]) begin
          e = exp_q.pop_front();
          m_data[c] = e[DW-1:0];
          check($sformatf("load%0d", c), pe_load[c], e[DW +: NPE]);
          if (c == 0) load0 = e[DW +: NPE];
        end else begin
          check($sformatf("load_idle%0d", c), pe_load[c], 0);
        end
        check($sformatf("data%0d", c), pe_data[c], m_data[c]);
        check($sformatf("miss%0d", c), miss[c], m_miss[c]);
        check($sformatf("drop_cnt%0d", c), drop_cnt[c], m_drop[c]);
      end
    end
    if (m_known) begin
      check("stall_cfg", s_cfg, !m_run[0]);
      check("stall_load", s_pe_load, load0);
      check("stall_data", s_pe_data, m_data[0]);
      check("stall_drop_cnt", s_drop_cnt, 0);
    end
    for (int c = 0; c < NCH; c++) begin
      mm  = mdl_match(c, tag_x[c], tag_y[c]);
      rdy = nrst && m_run[c] && ((mm != '0) ? &(pe_ready[c] | ~mm) : 1'b1);
      check($sformatf("in_ready%0d", c), in_ready[c], rdy);
      if (c == 0) begin
        check("stall_in_ready", s_in_ready, nrst && m_run[0] && (mm != '0) && &(pe_ready[0] | ~mm));
        check("stall_miss", s_miss, nrst && m_run[0] && in_valid[0] && (mm == '0));
      end
      acc = in_valid[c] && rdy;
      if (!nrst) begin
        model_reset(c);
      end else begin
        m_pend[c] = acc && (mm != '0);
        if (m_pend[c]) exp_q.push_back({c[0], mm, in_data[c]});
        m_miss[c] = acc && (mm == '0);
        if (m_miss[c] && m_drop[c] != 16'hFFFF) m_drop[c]++;
        if (scan_commit[c]) begin
          for (int i = 0; i < NPE; i++) m_xid[c][i] = m_chain[c][i];
          for (int i = 0; i < NY; i++)  m_yid[c][i] = m_chain[c][NPE+i];
        end
        if (scan_en[c]) begin
          for (int i = 0; i < L - 1; i++) m_chain[c][i] = m_chain[c][i+1];
          m_chain[c][L-1] = scan_data[c];
        end
        if (!m_run[c] && scan_commit[c] && !scan_en[c]) m_run[c] = 1'b1;
        else if (m_run[c] && scan_en[c]) m_run[c] = 1'b0;
      end
    end
    if (!nrst) m_known = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic scan_all(input logic [NCH-1:0] mask);
    for (int i = 0; i < L; i++) begin
      scan_en = mask;
      scan_data[0] = ids0[i];
      scan_data[1] = ids1[i];
      step();
    end
    scan_en = '0;
    scan_commit = mask;
    step();
    scan_commit = '0;
  endtask

  task automatic send(input int c, input logic [7:0] tx, input logic [7:0] ty, input logic [7:0] d);
    in_valid[c] = 1'b1; tag_x[c] = tx; tag_y[c] = ty; in_data[c] = d;
    step();
    in_valid[c] = 1'b0;
  endtask

  function automatic logic [7:0] rand_tag(input int c, input bit is_y);
    int r;
    r = $urandom_range(0, 5);
    if (r == 0) return 8'hFF;
    if (r == 1) return 8'($urandom_range(0, 255));
    if (is_y) return (c == 0) ? ids0[NPE + $urandom_range(0, NY-1)] : ids1[NPE + $urandom_range(0, NY-1)];
    return (c == 0) ? ids0[$urandom_range(0, NPE-1)] : ids1[$urandom_range(0, NPE-1)];
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0; n_fail = 0; m_known = 1'b0;
    for (int c = 0; c < NCH; c++) model_reset(c);
    nrst = 1'b0;
    scan_en = '0; scan_commit = '0; scan_data = '0;
    in_valid = '0; in_data = '0; tag_x = '0; tag_y = '0;
    pe_ready = '1;
    repeat (3) step();

    // First cycle out of reset must still refuse traffic.
    nrst = 1'b1;
    in_valid = '1; tag_x = '1; tag_y = '1;
    step();
    in_valid = '0;

    scan_all(2'b11);
    step();

    send(0, 8'd2, 8'd7, 8'h5A);
    step(); step();

    pe_ready[0][3] = 1'b0;
    in_valid[0] = 1'b1; tag_x[0] = 8'hFF; tag_y[0] = 8'd9; in_data[0] = 8'hC3;
    step(); step();
    pe_ready[0][3] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    step(); step();

    send(0, 8'd5, 8'd7, 8'h11);
    step(); step();

    in_valid = 2'b11;
    tag_x[0] = 8'd3; tag_y[0] = 8'd9; in_data[0] = 8'hA1;
    tag_x[1] = 8'd6; tag_y[1] = 8'd1; in_data[1] = 8'hB2;
    step(); step();
    in_valid = '0;
    step();

    for (int k = 0; k < 300; k++) begin
      for (int c = 0; c < NCH; c++) begin
        in_valid[c] = ($urandom_range(0, 3) != 0);
        tag_x[c] = rand_tag(c, 1'b0);
        tag_y[c] = rand_tag(c, 1'b1);
        in_data[c] = 8'($urandom_range(0, 255));
        for (int p = 0; p < NPE; p++) pe_ready[c][p] = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    in_valid = '0; pe_ready = '1;
    step();

    // Reconfiguration requested in the middle of a burst.
    in_valid[0] = 1'b1; tag_x[0] = 8'hFF; tag_y[0] = 8'd7;
    for (int k = 0; k < 4; k++) begin
      in_data[0] = 8'(8'h60 + k);
      if (k == 2) scan_en[0] = 1'b1;
      step();
    end
    in_valid[0] = 1'b0; scan_en = '0;
    step(); step();
    scan_all(2'b01);
    step();

    // Reset lands one cycle after an accepted word.
    in_valid[0] = 1'b1; tag_x[0] = 8'd2; tag_y[0] = 8'd7; in_data[0] = 8'h77;
    step();
    nrst = 1'b0;
    step();
    nrst = 1'b1; in_valid[0] = 1'b0;
    step(); step(); step();

    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
